// File: rtl/mips_mem_pkg.sv
// Shared encodings for the load/store front end: access sizes, FSM states, memory index width.
package mips_mem_pkg;

   localparam int DM_IDX_W = 8;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_RMW_RD = 3'd2,
      ST_STORE  = 3'd3,
      ST_DONE   = 3'd4
   } lsu_state_e;

   // Size 11 is never a legal access; halves need an even lane, words lane 0.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      logic mis;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = lane[0];
         SZ_WORD: mis = (lane != 2'b00);
         default: mis = 1'b1;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lane_merge.sv
// Byte/half lane extraction with sign/zero extension for loads, and lane replacement for stores.
// Purely combinational, no latency; no handshake, so no backpressure.
// Lanes are little-endian: lane 0 is bits [7:0].
module lane_merge
   import mips_mem_pkg::*;
(
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] rd_word,
   input  logic [31:0] old_word,
   input  logic [31:0] new_data,
   output logic [31:0] load_ext,
   output logic [31:0] merged
);

   logic [31:0] shifted;

   always_comb begin
      shifted  = rd_word >> {lane, 3'b000};
      load_ext = rd_word;
      case (size)
         SZ_BYTE: load_ext = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
         SZ_HALF: load_ext = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
         default: load_ext = rd_word;
      endcase
   end

   always_comb begin
      merged = old_word;
      case (size)
         SZ_BYTE: merged[{lane, 3'b000} +: 8]     = new_data[7:0];
         SZ_HALF: merged[{lane[1], 4'b0000} +: 16] = new_data[15:0];
         SZ_WORD: merged = new_data;
         default: merged = old_word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end onto a 256-word data memory; sub-word stores are read-modify-write.
// Latency accept->done: misaligned 1, load 2, word store 2, sub-word store 3 cycles.
// req_ready is high only in IDLE; CPU inputs are ignored while a request is in flight.
module load_store_unit
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              done,
   output logic [31:0]       load_data,
   output logic              misaligned,
   output logic [31:0]       dm_read_adr,
   output logic [31:0]       dm_write_adr,
   output logic [31:0]       dm_write_data,
   output logic              dm_memread,
   output logic              dm_memwrite,
   input  logic [31:0]       dm_read_data
);

   generate
      if (DATA_W != 32) begin : g_bad_data_w
         $error("load_store_unit: DATA_W must be 32");
      end
   endgenerate

   lsu_state_e          state_q, state_d;
   logic                we_q, we_d;
   logic [1:0]          size_q, size_d;
   logic                signed_q, signed_d;
   logic [DM_IDX_W-1:0] idx_q, idx_d;
   logic [1:0]          lane_q, lane_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         merge_q, merge_d;
   logic [31:0]         load_data_q, load_data_d;
   logic                mis_q, mis_d;

   logic [31:0]         lm_load_ext;
   logic [31:0]         lm_merged;
   logic [31:0]         idx_ext;
   logic                unused_addr_hi;

   // Only the word index and lane bits address the 1 KiB memory window.
   assign unused_addr_hi = ^req_addr[ADDR_W-1:10];
   assign idx_ext        = {{(32-DM_IDX_W){1'b0}}, idx_q};

   lane_merge u_lane_merge (
      .lane     (lane_q),
      .size     (size_q),
      .sign_ext (signed_q),
      .rd_word  (dm_read_data),
      .old_word (merge_q),
      .new_data (wdata_q),
      .load_ext (lm_load_ext),
      .merged   (lm_merged)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         we_q        <= 1'b0;
         size_q      <= SZ_BYTE;
         signed_q    <= 1'b0;
         idx_q       <= '0;
         lane_q      <= 2'b00;
         wdata_q     <= '0;
         merge_q     <= '0;
         load_data_q <= '0;
         mis_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         size_q      <= size_d;
         signed_q    <= signed_d;
         idx_q       <= idx_d;
         lane_q      <= lane_d;
         wdata_q     <= wdata_d;
         merge_q     <= merge_d;
         load_data_q <= load_data_d;
         mis_q       <= mis_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      size_d      = size_q;
      signed_d    = signed_q;
      idx_d       = idx_q;
      lane_d      = lane_q;
      wdata_d     = wdata_q;
      merge_d     = merge_q;
      load_data_d = load_data_q;
      mis_d       = mis_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d     = req_we;
               size_d   = req_size;
               signed_d = req_signed;
               idx_d    = req_addr[9:2];
               lane_d   = req_addr[1:0];
               wdata_d  = req_wdata;
               if (is_misaligned(req_size, req_addr[1:0])) begin
                  mis_d   = 1'b1;
                  state_d = ST_DONE;
               end else if (!req_we) begin
                  state_d = ST_LOAD;
               end else if (req_size == SZ_WORD) begin
                  state_d = ST_STORE;
               end else begin
                  state_d = ST_RMW_RD;
               end
            end
         end
         ST_LOAD: begin
            load_data_d = lm_load_ext;
            state_d     = ST_DONE;
         end
         ST_RMW_RD: begin
            merge_d = dm_read_data;
            state_d = ST_STORE;
         end
         ST_STORE: begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            mis_d   = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready     = 1'b0;
      done          = 1'b0;
      dm_read_adr   = '0;
      dm_write_adr  = '0;
      dm_write_data = '0;
      dm_memread    = 1'b0;
      dm_memwrite   = 1'b0;
      case (state_q)
         ST_IDLE: req_ready = 1'b1;
         ST_LOAD, ST_RMW_RD: begin
            dm_memread  = 1'b1;
            dm_read_adr = idx_ext;
         end
         ST_STORE: begin
            dm_memwrite   = 1'b1;
            dm_write_adr  = idx_ext;
            dm_write_data = (size_q == SZ_WORD) ? wdata_q : lm_merged;
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   assign load_data  = load_data_q;
   assign misaligned = mis_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural data memory, byte-level reference model, directed and random requests.
module tb_load_store_unit;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        done;
   logic [31:0] load_data;
   logic        misaligned;
   logic [31:0] dm_read_adr;
   logic [31:0] dm_write_adr;
   logic [31:0] dm_write_data;
   logic        dm_memread;
   logic        dm_memwrite;
   logic [31:0] dm_read_data;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem     [0:255];
   logic [31:0] ref_mem [0:255];
   logic [31:0] last_ld;

   load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_we        (req_we),
      .req_size      (req_size),
      .req_signed    (req_signed),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .done          (done),
      .load_data     (load_data),
      .misaligned    (misaligned),
      .dm_read_adr   (dm_read_adr),
      .dm_write_adr  (dm_write_adr),
      .dm_write_data (dm_write_data),
      .dm_memread    (dm_memread),
      .dm_memwrite   (dm_memwrite),
      .dm_read_data  (dm_read_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // data_memory: reset (from inverted reset) loads mem[i]=i, synchronous write, combinational read.
   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
      end else if (dm_memwrite) begin
         mem[dm_write_adr[7:0]] <= dm_write_data;
      end
   end
   assign dm_read_data = mem[dm_read_adr[7:0]];

   function automatic logic [7:0] ref_get(input int a);
      logic [31:0] w;
      w = ref_mem[(a >> 2) & 255];
      return 8'((w >> (8 * (a % 4))) & 32'hFF);
   endfunction

   task automatic ref_set(input int a, input logic [7:0] b);
      int i;
      int s;
      i = (a >> 2) & 255;
      s = 8 * (a % 4);
      ref_mem[i] = (ref_mem[i] & ~(32'hFF << s)) | (32'(b) << s);
   endtask

   task automatic ref_req(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat, output int nrd, output int nwr,
                          output logic mis, output logic [31:0] ld);
      int a;
      int nb;
      logic [31:0] val;
      a   = int'(addr[9:0]);
      nb  = 1 << sz;
      mis = (sz == 2'b11) || (sz == 2'b01 && (a % 2) != 0) || (sz == 2'b10 && (a % 4) != 0);
      if (mis) begin
         lat = 1; nrd = 0; nwr = 0;
      end else if (!we) begin
         val = 32'h0;
         for (int i = 0; i < nb; i++) val = val | (32'(ref_get(a + i)) << (8 * i));
         if (sg && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8 * nb));
         last_ld = val;
         lat = 2; nrd = 1; nwr = 0;
      end else begin
         for (int i = 0; i < nb; i++) ref_set(a + i, 8'((wd >> (8 * i)) & 32'hFF));
         lat = (nb == 4) ? 2 : 3;
         nrd = (nb == 4) ? 0 : 1;
         nwr = 1;
      end
      ld = last_ld;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset     = 1'b0;
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({req_ready, done, misaligned, dm_memread, dm_memwrite} !== 5'b10000) begin
         bad++;
         $display("FAIL reset_ctrl_during got=%b want=10000", {req_ready, done, misaligned, dm_memread, dm_memwrite});
      end
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i);
      last_ld = 32'h0;
   endtask

   // Issues one request from IDLE and watches it to completion, checking dm_* each cycle.
   task automatic do_req(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output int nrd, output int nwr,
                         output logic [31:0] ld, output logic mis);
      logic [31:0] idx;
      idx = {24'h0, addr[9:2]};
      lat = -1; nrd = 0; nwr = 0; ld = 32'h0; mis = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL ready_before_accept got=%b want=1", req_ready);
      end
      @(posedge clk);
      #1;
      for (int k = 1; k <= 8; k++) begin
         req_valid = 1'($urandom); req_we = 1'($urandom); req_size = 2'($urandom);
         req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
         total++;
         if (dm_memread === 1'b1 && dm_memwrite === 1'b1) begin
            bad++;
            $display("FAIL read_write_overlap cycle=%0d got=11 want=not both", k);
         end
         if (dm_memread === 1'b1) begin
            nrd++;
            total++;
            if (dm_read_adr !== idx) begin
               bad++;
               $display("FAIL read_adr got=%h want=%h", dm_read_adr, idx);
            end
         end
         if (dm_memwrite === 1'b1) begin
            nwr++;
            total++;
            if (dm_write_adr !== idx) begin
               bad++;
               $display("FAIL write_adr got=%h want=%h", dm_write_adr, idx);
            end
         end
         if (dm_memread !== 1'b1 && dm_memwrite !== 1'b1) begin
            total++;
            if ({dm_read_adr, dm_write_adr, dm_write_data} !== 96'h0) begin
               bad++;
               $display("FAIL dm_idle_zero got=%h/%h/%h want=0", dm_read_adr, dm_write_adr, dm_write_data);
            end
         end
         if (done === 1'b1) begin
            lat = k; ld = load_data; mis = misaligned;
            req_valid = 1'b0;
            break;
         end
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      if (lat < 0) begin
         total++;
         bad++;
         $display("FAIL done_timeout got=no done want=done within 8 cycles");
      end else begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      total++;
      if ({req_ready, done, misaligned, dm_memread, dm_memwrite} !== 5'b10000) begin
         bad++;
         $display("FAIL reset_ctrl got=%b want=10000", {req_ready, done, misaligned, dm_memread, dm_memwrite});
      end
      total++;
      if ({load_data, dm_read_adr, dm_write_adr, dm_write_data} !== 128'h0) begin
         bad++;
         $display("FAIL reset_data got=%h want=0", {load_data, dm_read_adr, dm_write_adr, dm_write_data});
      end
   endtask

   task automatic test_load_word();
      int lat, nrd, nwr;
      logic [31:0] ld;
      logic mis;
      apply_reset();
      do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, lat, nrd, nwr, ld, mis);
      total++; if (lat !== 2) begin bad++; $display("FAIL lw_latency got=%0d want=2", lat); end
      total++; if (ld !== 32'h5) begin bad++; $display("FAIL lw_data got=%h want=00000005", ld); end
      total++; if (nrd !== 1 || nwr !== 0 || mis !== 1'b0) begin
         bad++; $display("FAIL lw_access got=rd%0d wr%0d mis%b want=rd1 wr0 mis0", nrd, nwr, mis);
      end
   endtask

   task automatic test_store_byte();
      int lat, nrd, nwr;
      logic [31:0] ld;
      logic mis;
      apply_reset();
      do_req(1'b1, 2'b00, 1'b0, 32'h09, 32'h0000_00AB, lat, nrd, nwr, ld, mis);
      total++; if (lat !== 3) begin bad++; $display("FAIL sb_latency got=%0d want=3", lat); end
      total++; if (nrd !== 1 || nwr !== 1) begin
         bad++; $display("FAIL sb_access got=rd%0d wr%0d want=rd1 wr1", nrd, nwr);
      end
      total++; if (mem[2] !== 32'h0000_AB02) begin bad++; $display("FAIL sb_mem got=%h want=0000ab02", mem[2]); end
   endtask

   task automatic test_byte_loads();
      int lat, nrd, nwr;
      logic [31:0] ld;
      logic mis;
      do_req(1'b0, 2'b00, 1'b1, 32'h09, 32'h0, lat, nrd, nwr, ld, mis);
      total++; if (ld !== 32'hFFFF_FFAB) begin bad++; $display("FAIL lb_signed got=%h want=ffffffab", ld); end
      do_req(1'b0, 2'b00, 1'b0, 32'h09, 32'h0, lat, nrd, nwr, ld, mis);
      total++; if (ld !== 32'h0000_00AB) begin bad++; $display("FAIL lbu got=%h want=000000ab", ld); end
      do_req(1'b0, 2'b00, 1'b0, 32'h08, 32'h0, lat, nrd, nwr, ld, mis);
      total++; if (ld !== 32'h0000_0002) begin bad++; $display("FAIL lbu_lane0 got=%h want=00000002", ld); end
   endtask

   task automatic test_half();
      int lat, nrd, nwr;
      logic [31:0] ld;
      logic mis;
      apply_reset();
      do_req(1'b1, 2'b01, 1'b0, 32'h0E, 32'h1234_ABCD, lat, nrd, nwr, ld, mis);
      total++; if (mem[3] !== 32'hABCD_0003) begin bad++; $display("FAIL sh_mem got=%h want=abcd0003", mem[3]); end
      do_req(1'b0, 2'b01, 1'b1, 32'h0E, 32'h0, lat, nrd, nwr, ld, mis);
      total++; if (ld !== 32'hFFFF_ABCD || lat !== 2) begin
         bad++; $display("FAIL lh_signed got=%h lat%0d want=ffffabcd lat2", ld, lat);
      end
   endtask

   task automatic test_misaligned();
      int lat, nrd, nwr;
      logic [31:0] ld;
      logic mis;
      apply_reset();
      do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, lat, nrd, nwr, ld, mis);
      total++; if (mis !== 1'b1 || lat !== 1) begin
         bad++; $display("FAIL mis_lw got=mis%b lat%0d want=mis1 lat1", mis, lat);
      end
      total++; if (nrd !== 0 || nwr !== 0 || ld !== 32'h0) begin
         bad++; $display("FAIL mis_lw_access got=rd%0d wr%0d ld%h want=rd0 wr0 ld0", nrd, nwr, ld);
      end
      total++; if (misaligned !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL mis_clear got=mis%b done%b want=0 0", misaligned, done);
      end
      do_req(1'b1, 2'b01, 1'b0, 32'h03, 32'hDEAD_BEEF, lat, nrd, nwr, ld, mis);
      total++; if (mis !== 1'b1 || lat !== 1 || nrd !== 0 || nwr !== 0) begin
         bad++; $display("FAIL mis_sh got=mis%b lat%0d rd%0d wr%0d want=mis1 lat1 rd0 wr0", mis, lat, nrd, nwr);
      end
      total++; if (mem[0] !== 32'h0) begin bad++; $display("FAIL mis_sh_mem got=%h want=00000000", mem[0]); end
   endtask

   task automatic test_reset_mid_op();
      int nwr;
      apply_reset();
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h09; req_wdata = 32'h0000_00AB;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      total++; if (dm_memread !== 1'b1) begin bad++; $display("FAIL mid_rmw_read got=%b want=1", dm_memread); end
      reset = 1'b0;
      nwr = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         if (dm_memwrite === 1'b1) nwr++;
      end
      total++;
      if ({done, misaligned, dm_memread, dm_memwrite, load_data, dm_read_adr, dm_write_adr, dm_write_data} !== 132'h0) begin
         bad++; $display("FAIL mid_outputs_zero got=%b%b%b%b want=0000", done, misaligned, dm_memread, dm_memwrite);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      if (dm_memwrite === 1'b1) nwr++;
      total++; if (nwr !== 0) begin bad++; $display("FAIL mid_no_write got=%0d want=0", nwr); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b want=1", req_ready); end
      total++; if (mem[2] !== 32'h2) begin bad++; $display("FAIL mid_mem got=%h want=00000002", mem[2]); end
   endtask

   task automatic test_back_to_back();
      logic exp_done;
      apply_reset();
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
      req_addr = 32'h14; req_wdata = 32'h0;
      for (int t = 0; t < 12; t++) begin
         @(posedge clk);
         #1;
         exp_done = ((t % 3) == 1);
         total++;
         if (done !== exp_done) begin
            bad++; $display("FAIL b2b_done t=%0d got=%b want=%b", t, done, exp_done);
         end
         if (exp_done) begin
            total++;
            if (load_data !== 32'h5) begin bad++; $display("FAIL b2b_data t=%0d got=%h want=00000005", t, load_data); end
         end
      end
      req_valid = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_random();
      int lat, nrd, nwr, elat, enrd, enwr, nbad;
      logic [31:0] ld, eld, addr, wd;
      logic mis, emis, we, sg;
      logic [1:0] sz;
      apply_reset();
      for (int n = 0; n < 80; n++) begin
         we   = 1'($urandom);
         sz   = 2'($urandom);
         sg   = 1'($urandom);
         addr = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
         wd   = $urandom;
         ref_req(we, sz, sg, addr, wd, elat, enrd, enwr, emis, eld);
         do_req(we, sz, sg, addr, wd, lat, nrd, nwr, ld, mis);
         total++;
         if (lat !== elat || mis !== emis || nrd !== enrd || nwr !== enwr || ld !== eld) begin
            bad++;
            $display("FAIL rand_req n=%0d we%b sz%0d sg%b a=%h got=lat%0d mis%b rd%0d wr%0d ld%h want=lat%0d mis%b rd%0d wr%0d ld%h",
                     n, we, sz, sg, addr, lat, mis, nrd, nwr, ld, elat, emis, enrd, enwr, eld);
         end
      end
      nbad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nbad++;
      total++;
      if (nbad != 0) begin bad++; $display("FAIL rand_mem got=%0d words differ want=0", nbad); end
   endtask

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      test_reset();
      test_load_word();
      test_store_byte();
      test_byte_loads();
      test_half();
      test_misaligned();
      test_reset_mid_op();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
